arp_request_parser: RTL and testbench
=====================================

Name: arp_request_parser

Overview:
Receive-side companion of the ARP answer former. Consumes the PHY MII receive nibble stream and detects Ethernet ARP requests addressed to the board's IP. Captures the requester's MAC and IP onto PC_MAC/PC_IP. Issues a one-cycle request pulse that drives the answer former's ena input, held off while the former is transmitting.

Parameters:
MIN_PREAMBLE, 7, minimum count of 0x5 nibbles required before the 0xD SFD nibble
MIN_FRAME, 64, minimum frame length in bytes, destination MAC through FCS inclusive
LEN_W, 11, width of the byte counter; saturates at all-ones

Ports:
clock  in  1  receive clock, the same clock as the answer former
reset_n  in  1  asynchronous active-low reset
rx_dv  in  1  MII receive data valid
rx_er  in  1  MII receive error
rxd  in  4  MII receive nibble; low nibble of each byte arrives first
BOARD_MAC  in  48  board MAC, quasi-static
BOARD_IP  in  32  board IP, quasi-static
tx_busy  in  1  answer former transmitting; connect to the former's tx_en
PC_MAC  out  48  sender hardware address (SHA) of the last accepted request
PC_IP  out  32  sender protocol address (SPA) of the last accepted request
arp_req  out  1  one-cycle pulse; connect to the former's ena
req_count  out  16  count of accepted requests; wraps at 0xFFFF to 0

Behaviour:
- Reset (asynchronous, reset_n=0):
  - PC_MAC=0, PC_IP=0, arp_req=0, req_count=0.
  - Internal state: pending=0, FSM=IDLE, counters=0.
- FSM states: IDLE, PREAMBLE, DATA, WAIT_END, DROP. All inputs are sampled on the rising edge of clock.
- IDLE: on rx_dv=1, go to PREAMBLE.
  - If the first nibble is 0x5, the preamble count is 1.
  - Otherwise go to DROP.
- PREAMBLE:
  - Nibble 0x5: increment the preamble count; it saturates at 15.
  - Nibble 0xD with count >= MIN_PREAMBLE: go to DATA with the byte index at 0.
  - Any other nibble, or 0xD with too short a preamble: go to DROP.
- DATA byte assembly: the first nibble goes to byte[3:0], the second to byte[7:4]. The byte index increments after each second nibble.
- Byte checks, where "mismatch" means go to DROP:
  - 0-5: destination MAC is either all 0xFF or equal to BOARD_MAC. The check is for the whole 6 bytes; broadcast and unicast may not be mixed.
  - 6-11: source MAC is ignored.
  - 12-13: ethertype 08 06.
  - 14-15: HTYPE 00 01.
  - 16-17: PTYPE 08 00.
  - 18: HLEN 06.
  - 19: PLEN 04.
  - 20-21: OPER 00 01. Replies are dropped.
  - 22-27: SHA is shifted into the shadow register sha_s, MSB byte first.
  - 28-31: SPA is shifted into spa_s, MSB byte first.
  - 32-37: THA is ignored.
  - 38-41: TPA must equal BOARD_IP byte-wise, MSB first. After byte 41 matches, go to WAIT_END.
- WAIT_END:
  - Keep counting bytes (padding and FCS are not checked).
  - On rx_dv=0, accept only if byte count >= MIN_FRAME and the nibble phase is even; otherwise discard.
  - Then go to IDLE.
- rx_dv falling while in PREAMBLE or DATA: discard and go to IDLE.
- rx_er=1 in any state other than IDLE: go to DROP.
- DROP: wait for rx_dv=0, then go to IDLE. There are no output side effects.
- Accept at clock edge E:
  - PC_MAC <= sha_s, PC_IP <= spa_s, pending <= 1, req_count increments.
  - PC_MAC/PC_IP change only at accept edges; they are otherwise stable.
- Pulse:
  - When pending=1 and tx_busy=0 at edge E+k (k>=1), arp_req=1 for exactly that cycle and pending clears.
  - Minimum latency is arp_req high in the cycle after E.
- Accept while pending=1: PC_MAC/PC_IP are overwritten with the newer data. Only one pulse is issued; requests coalesce.
- Accept in the same cycle as a pulse: the pulse completes, and pending is set again for the new request.
- Shadow registers are not visible on outputs. A dropped frame never alters PC_MAC/PC_IP.
- rx_dv=1 with no gap after WAIT_END or DROP ends is treated as a new frame starting in IDLE on the next cycle.
- Byte counter saturates at 2^LEN_W-1 and does not wrap.

Test Plan:
1. Broadcast ARP request: 15x 0x5, then 0xD; SHA=00:1B:21:0A:0B:0C, SPA=192.168.1.10, TPA=BOARD_IP=192.168.1.2; 42 bytes + 18 pad + 4 FCS; tx_busy=0 -> PC_MAC=0x001B210A0B0C, PC_IP=0xC0A8010A, arp_req high for 1 cycle exactly 1 clock after the edge sampling rx_dv=0, req_count=1.
2. Same frame with TPA=192.168.1.3, and a second variant with OPER=00 02 -> no arp_req; PC_MAC/PC_IP keep the previous values; req_count unchanged.
3. Valid request with tx_busy=1 for 200 cycles after accept -> arp_req stays 0, then pulses in the first cycle tx_busy=0. Two valid requests during busy -> a single pulse, outputs carry the second request's SHA/SPA.
4. Runt: rx_dv drops after byte 30 -> discarded. 50-byte frame with valid fields -> discarded. Preamble of 5 nibbles -> DROP, no pulse.
5. Frame with rx_er=1 at byte 25 -> no pulse. The next valid frame back-to-back is accepted normally.
6. reset_n=0 mid-DATA of a valid frame -> all outputs 0 immediately (asynchronous). After release, the next valid frame yields arp_req and req_count=1.

Source files
------------

// File: rtl/arp_request_parser_if.sv
// rtl/arp_request_parser_if.sv - MII receive nibble bus between PHY and ARP request parser
//
// Signals:
//   rx_dv  receive data valid
//   rx_er  receive error
//   rxd    receive nibble, low nibble of each byte first
// Modports:
//   master  PHY side, drives the bus
//   slave   parser side, samples the bus

interface arp_request_parser_if;
    logic       rx_dv;
    logic       rx_er;
    logic [3:0] rxd;

    modport master (output rx_dv, output rx_er, output rxd);
    modport slave  (input  rx_dv, input  rx_er, input  rxd);
endinterface

// File: rtl/arp_request_parser.sv
// rtl/arp_request_parser.sv - detects ARP requests for the board IP on an MII receive stream
//
// Ports:
//   clock      receive clock, shared with the answer former
//   reset_n    asynchronous active-low reset
//   mii        MII receive bus (rx_dv, rx_er, rxd)
//   BOARD_MAC  board MAC address, quasi-static
//   BOARD_IP   board IP address, quasi-static
//   tx_busy    answer former transmitting; holds the request pulse off
//   PC_MAC     sender hardware address of the last accepted request
//   PC_IP      sender protocol address of the last accepted request
//   arp_req    one-cycle request pulse to the answer former
//   req_count  number of accepted requests, wrapping

module arp_request_parser #(
    parameter int MIN_PREAMBLE = 7,
    parameter int MIN_FRAME    = 64,
    parameter int LEN_W        = 11
) (
    input  logic                 clock,
    input  logic                 reset_n,
    arp_request_parser_if.slave  mii,
    input  logic [47:0]          BOARD_MAC,
    input  logic [31:0]          BOARD_IP,
    input  logic                 tx_busy,
    output logic [47:0]          PC_MAC,
    output logic [31:0]          PC_IP,
    output logic                 arp_req,
    output logic [15:0]          req_count
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, WAIT_END, DROP} state_t;

    state_t           state, state_n;
    logic [3:0]       pre_cnt, pre_cnt_n;
    logic [LEN_W-1:0] byte_cnt, byte_cnt_n;
    logic             phase, phase_n;
    logic [3:0]       lo_nib, lo_nib_n;
    logic             bcast_ok, bcast_n;
    logic             ucast_ok, ucast_n;
    logic [47:0]      sha_s, sha_n;
    logic [31:0]      spa_s, spa_n;
    logic             pending;
    logic             accept;

    logic [7:0]       cur_byte;
    logic [7:0]       exp_byte;
    logic [7:0]       mac_b;
    logic [7:0]       ip_b;
    logic             mismatch;
    int               idx;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_n    = state;
        pre_cnt_n  = pre_cnt;
        byte_cnt_n = byte_cnt;
        phase_n    = phase;
        lo_nib_n   = lo_nib;
        bcast_n    = bcast_ok;
        ucast_n    = ucast_ok;
        sha_n      = sha_s;
        spa_n      = spa_s;
        accept     = 1'b0;
        cur_byte   = {mii.rxd, lo_nib};
        idx        = int'(byte_cnt);
        exp_byte   = 8'h00;
        mac_b      = 8'h00;
        ip_b       = 8'h00;
        mismatch   = 1'b0;

        case (state)
            IDLE: begin
                byte_cnt_n = '0;
                phase_n    = 1'b0;
                bcast_n    = 1'b1;
                ucast_n    = 1'b1;
                pre_cnt_n  = 4'd0;
                if (mii.rx_dv) begin
                    if (mii.rxd == 4'h5) begin
                        state_n   = PREAMBLE;
                        pre_cnt_n = 4'd1;
                    end else begin
                        state_n = DROP;
                    end
                end
            end

            PREAMBLE: begin
                if (!mii.rx_dv) begin
                    state_n = IDLE;
                end else if (mii.rx_er) begin
                    state_n = DROP;
                end else if (mii.rxd == 4'h5) begin
                    pre_cnt_n = (pre_cnt == 4'hF) ? pre_cnt : pre_cnt + 4'd1;
                end else if (mii.rxd == 4'hD && pre_cnt >= 4'(MIN_PREAMBLE)) begin
                    state_n    = DATA;
                    byte_cnt_n = '0;
                    phase_n    = 1'b0;
                end else begin
                    state_n = DROP;
                end
            end

            DATA: begin
                if (!mii.rx_dv) begin
                    state_n = IDLE;
                end else if (mii.rx_er) begin
                    state_n = DROP;
                end else if (!phase) begin
                    lo_nib_n = mii.rxd;
                    phase_n  = 1'b1;
                end else begin
                    phase_n    = 1'b0;
                    byte_cnt_n = sat_inc(byte_cnt);
                    if (idx <= 5) begin
                        // Broadcast and unicast qualifiers are tracked separately so a
                        // destination mixing both patterns fails on both.
                        mac_b    = BOARD_MAC[8*(5-idx) +: 8];
                        bcast_n  = bcast_ok && (cur_byte == 8'hFF);
                        ucast_n  = ucast_ok && (cur_byte == mac_b);
                        mismatch = !bcast_n && !ucast_n;
                    end else if (idx >= 12 && idx <= 21) begin
                        case (idx)
                            12:      exp_byte = 8'h08;
                            13:      exp_byte = 8'h06;
                            14:      exp_byte = 8'h00;
                            15:      exp_byte = 8'h01;
                            16:      exp_byte = 8'h08;
                            17:      exp_byte = 8'h00;
                            18:      exp_byte = 8'h06;
                            19:      exp_byte = 8'h04;
                            20:      exp_byte = 8'h00;
                            default: exp_byte = 8'h01;
                        endcase
                        mismatch = (cur_byte != exp_byte);
                    end else if (idx >= 22 && idx <= 27) begin
                        sha_n = {sha_s[39:0], cur_byte};
                    end else if (idx >= 28 && idx <= 31) begin
                        spa_n = {spa_s[23:0], cur_byte};
                    end else if (idx >= 38 && idx <= 41) begin
                        ip_b     = BOARD_IP[8*(41-idx) +: 8];
                        mismatch = (cur_byte != ip_b);
                    end

                    if (mismatch) begin
                        state_n = DROP;
                    end else if (idx == 41) begin
                        state_n = WAIT_END;
                    end
                end
            end

            WAIT_END: begin
                if (!mii.rx_dv) begin
                    // An odd nibble count means a torn final byte; discard such frames.
                    if (byte_cnt >= LEN_W'(MIN_FRAME) && !phase) begin
                        accept = 1'b1;
                    end
                    state_n = IDLE;
                end else if (mii.rx_er) begin
                    state_n = DROP;
                end else if (!phase) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n    = 1'b0;
                    byte_cnt_n = sat_inc(byte_cnt);
                end
            end

            DROP: begin
                if (!mii.rx_dv) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pre_cnt  <= 4'd0;
            byte_cnt <= '0;
            phase    <= 1'b0;
            lo_nib   <= 4'd0;
            bcast_ok <= 1'b0;
            ucast_ok <= 1'b0;
            sha_s    <= 48'd0;
            spa_s    <= 32'd0;
        end else begin
            state    <= state_n;
            pre_cnt  <= pre_cnt_n;
            byte_cnt <= byte_cnt_n;
            phase    <= phase_n;
            lo_nib   <= lo_nib_n;
            bcast_ok <= bcast_n;
            ucast_ok <= ucast_n;
            sha_s    <= sha_n;
            spa_s    <= spa_n;
        end
    end

    // A pulse and a new accept on the same edge: the pulse completes and the
    // later assignment re-arms pending for the new request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            PC_MAC    <= 48'd0;
            PC_IP     <= 32'd0;
            arp_req   <= 1'b0;
            req_count <= 16'd0;
            pending   <= 1'b0;
        end else begin
            arp_req <= 1'b0;
            if (pending && !tx_busy) begin
                arp_req <= 1'b1;
                pending <= 1'b0;
            end
            if (accept) begin
                PC_MAC    <= sha_s;
                PC_IP     <= spa_s;
                pending   <= 1'b1;
                req_count <= req_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_arp_request_parser.sv
// tb/tb_arp_request_parser.sv - scoreboard testbench for arp_request_parser

module tb_arp_request_parser;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        tx_busy = 1'b0;
    logic [47:0] pc_mac;
    logic [31:0] pc_ip;
    logic        arp_req;
    logic [15:0] req_count;
    logic [47:0] board_mac = 48'h02AABBCCDDEE;
    logic [31:0] board_ip  = 32'hC0A80102;

    arp_request_parser_if mii();

    always #5 clock = ~clock;

    arp_request_parser dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .mii       (mii),
        .BOARD_MAC (board_mac),
        .BOARD_IP  (board_ip),
        .tx_busy   (tx_busy),
        .PC_MAC    (pc_mac),
        .PC_IP     (pc_ip),
        .arp_req   (arp_req),
        .req_count (req_count)
    );

    typedef struct {
        logic [47:0] mac;
        logic [31:0] ip;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [47:0] last_mac = 48'd0;
    logic [31:0] last_ip = 32'd0;
    logic [7:0]  fb[64];

    localparam logic [47:0] SHA_A = 48'h001B210A0B0C;
    localparam logic [31:0] SPA_A = 32'hC0A8010A;
    localparam logic [47:0] SHA_B = 48'h00E04C112233;
    localparam logic [31:0] SPA_B = 32'hC0A80114;
    localparam logic [47:0] SHA_C = 48'h3C970E445566;
    localparam logic [31:0] SPA_C = 32'hC0A8011E;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest expected request.
    always @(negedge clock) begin
        exp_t e;
        if (arp_req === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: arp_req=1 at cycle %0d, required 0", cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("pulse_mac", pc_mac, e.mac);
                check("pulse_ip", pc_ip, e.ip);
                check("pulse_count", req_count, e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // dst_mode: 0 broadcast, 1 unicast to board, 2 mixed broadcast/unicast
    task automatic build(input int dst_mode, input logic [47:0] sha, input logic [31:0] spa,
                         input logic [31:0] tpa, input logic [7:0] oper);
        for (int i = 0; i < 64; i++) fb[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            case (dst_mode)
                0:       fb[i] = 8'hFF;
                1:       fb[i] = board_mac[8*(5-i) +: 8];
                default: fb[i] = (i < 3) ? 8'hFF : board_mac[8*(5-i) +: 8];
            endcase
        end
        fb[6] = 8'h00; fb[7] = 8'h1B; fb[8] = 8'h21; fb[9] = 8'h99; fb[10] = 8'h88; fb[11] = 8'h77;
        fb[12] = 8'h08; fb[13] = 8'h06; fb[14] = 8'h00; fb[15] = 8'h01;
        fb[16] = 8'h08; fb[17] = 8'h00; fb[18] = 8'h06; fb[19] = 8'h04;
        fb[20] = 8'h00; fb[21] = oper;
        for (int i = 0; i < 6; i++) fb[22+i] = sha[8*(5-i) +: 8];
        for (int i = 0; i < 4; i++) fb[28+i] = spa[8*(3-i) +: 8];
        for (int i = 0; i < 4; i++) fb[38+i] = tpa[8*(3-i) +: 8];
        fb[60] = 8'hDE; fb[61] = 8'hAD; fb[62] = 8'hBE; fb[63] = 8'hEF;
    endtask

    task automatic send_frame(input int pre_n, input int nbytes, input int er_byte, input bit keep_dv);
        for (int p = 0; p < pre_n; p++) begin
            @(negedge clock);
            mii.rx_dv = 1'b1; mii.rx_er = 1'b0; mii.rxd = 4'h5;
        end
        @(negedge clock);
        mii.rxd = 4'hD;
        for (int b = 0; b < nbytes; b++) begin
            @(negedge clock);
            mii.rxd = fb[b][3:0];
            mii.rx_er = (b == er_byte);
            @(negedge clock);
            mii.rxd = fb[b][7:4];
            mii.rx_er = 1'b0;
        end
        if (!keep_dv) begin
            @(negedge clock);
            mii.rx_dv = 1'b0; mii.rx_er = 1'b0; mii.rxd = 4'h0;
        end
    endtask

    // Called at the negedge where rx_dv was just lowered: accept on the next
    // edge, pulse on the one after.
    task automatic expect_accept(input logic [47:0] mac, input logic [31:0] ip);
        exp_t e;
        exp_cnt++;
        last_mac = mac;
        last_ip = ip;
        e.mac = mac; e.ip = ip; e.cnt = exp_cnt; e.cyc = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_mac"}, pc_mac, last_mac);
        check({tag, "_ip"}, pc_ip, last_ip);
        check({tag, "_count"}, req_count, exp_cnt);
    endtask

    initial begin
        exp_t e;
        mii.rx_dv = 1'b0; mii.rx_er = 1'b0; mii.rxd = 4'h0;
        idle(2);
        check("reset_mac", pc_mac, 48'd0);
        check("reset_ip", pc_ip, 32'd0);
        check("reset_req", arp_req, 1'b0);
        check("reset_count", req_count, 16'd0);
        reset_n = 1'b1;
        idle(2);

        // Broadcast request for the board IP
        build(0, SHA_A, SPA_A, 32'hC0A80102, 8'h01);
        send_frame(15, 64, -1, 0);
        expect_accept(SHA_A, SPA_A);
        idle(6);
        check_held("t1");

        // Wrong TPA, then a reply
        build(0, SHA_B, SPA_B, 32'hC0A80103, 8'h01);
        send_frame(15, 64, -1, 0);
        idle(6);
        check_held("t2_tpa");
        build(0, SHA_B, SPA_B, 32'hC0A80102, 8'h02);
        send_frame(15, 64, -1, 0);
        idle(6);
        check_held("t2_oper");

        // Unicast request accepted, mixed destination dropped
        build(1, SHA_B, SPA_B, 32'hC0A80102, 8'h01);
        send_frame(7, 64, -1, 0);
        expect_accept(SHA_B, SPA_B);
        idle(6);
        check_held("unicast");
        build(2, SHA_C, SPA_C, 32'hC0A80102, 8'h01);
        send_frame(15, 64, -1, 0);
        idle(6);
        check_held("mixed_dst");

        // Held off by tx_busy for 200 cycles
        tx_busy = 1'b1;
        build(0, SHA_A, SPA_A, 32'hC0A80102, 8'h01);
        send_frame(15, 64, -1, 0);
        idle(200);
        exp_cnt++;
        last_mac = SHA_A; last_ip = SPA_A;
        check_held("busy_hold");
        e.mac = SHA_A; e.ip = SPA_A; e.cnt = exp_cnt; e.cyc = cyc + 1;
        sb.push_back(e);
        tx_busy = 1'b0;
        idle(4);

        // Two requests during busy coalesce into one pulse
        tx_busy = 1'b1;
        build(0, SHA_B, SPA_B, 32'hC0A80102, 8'h01);
        send_frame(15, 64, -1, 0);
        idle(3);
        build(0, SHA_C, SPA_C, 32'hC0A80102, 8'h01);
        send_frame(15, 64, -1, 0);
        idle(20);
        exp_cnt = exp_cnt + 16'd2;
        last_mac = SHA_C; last_ip = SPA_C;
        check_held("coalesce");
        e.mac = SHA_C; e.ip = SPA_C; e.cnt = exp_cnt; e.cyc = cyc + 1;
        sb.push_back(e);
        tx_busy = 1'b0;
        idle(4);

        // Runts and a short preamble
        build(0, SHA_B, SPA_B, 32'hC0A80102, 8'h01);
        send_frame(15, 31, -1, 0);
        idle(4);
        check_held("runt31");
        send_frame(15, 50, -1, 0);
        idle(4);
        check_held("runt50");
        send_frame(5, 64, -1, 0);
        idle(4);
        check_held("short_pre");

        // rx_er mid-frame, then a back-to-back valid frame
        build(0, SHA_B, SPA_B, 32'hC0A80102, 8'h01);
        send_frame(15, 64, 25, 0);
        build(0, SHA_A, SPA_A, 32'hC0A80102, 8'h01);
        send_frame(15, 64, -1, 0);
        expect_accept(SHA_A, SPA_A);
        idle(6);
        check_held("rx_er_b2b");

        // Asynchronous reset in the middle of a valid frame
        build(0, SHA_B, SPA_B, 32'hC0A80102, 8'h01);
        send_frame(15, 20, -1, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_mac", pc_mac, 48'd0);
        check("async_ip", pc_ip, 32'd0);
        check("async_req", arp_req, 1'b0);
        check("async_count", req_count, 16'd0);
        exp_cnt = 16'd0; last_mac = 48'd0; last_ip = 32'd0;
        @(negedge clock);
        mii.rx_dv = 1'b0; mii.rxd = 4'h0;
        idle(3);
        reset_n = 1'b1;
        idle(2);
        send_frame(15, 64, -1, 0);
        expect_accept(SHA_B, SPA_B);
        idle(6);
        check_held("post_reset");

        idle(10);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
